// File: rtl/jelly3_axi4s_packet_arbiter_pkg.sv
// Shared types for the AXI4-Stream packet arbiter family.
package jelly3_axi4s_arb_pkg;

    localparam int MAX_NUM_S = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/jelly3_axi4s_packet_arbiter_if.sv
// Source-side and output-side stream signals of the packet arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface jelly3_axi4s_packet_arbiter_if #(
    parameter int NUM_S     = 4,
    parameter int SEL_BITS  = (NUM_S > 1) ? $clog2(NUM_S) : 1,
    parameter int DATA_BITS = 32,
    parameter int USER_BITS = 1
);
    import jelly3_axi4s_arb_pkg::*;

    logic [NUM_S*DATA_BITS-1:0] s_tdata;
    logic [NUM_S*USER_BITS-1:0] s_tuser;
    logic [NUM_S-1:0]           s_tlast;
    logic [NUM_S-1:0]           s_tvalid;
    logic [NUM_S-1:0]           s_tready;

    logic [DATA_BITS-1:0]       m_tdata;
    logic [USER_BITS-1:0]       m_tuser;
    logic                       m_tlast;
    logic [SEL_BITS-1:0]        m_tid;
    logic                       m_tvalid;
    logic                       m_tready;

    modport master (
        input  s_tdata, s_tuser, s_tlast, s_tvalid, m_tready,
        output s_tready, m_tdata, m_tuser, m_tlast, m_tid, m_tvalid
    );

    modport slave (
        output s_tdata, s_tuser, s_tlast, s_tvalid, m_tready,
        input  s_tready, m_tdata, m_tuser, m_tlast, m_tid, m_tvalid
    );

endinterface

// File: rtl/jelly3_rr_select.sv
// Combinational round-robin pick: first set request after 'last', wrapping around.
// Zero latency; no handshake of its own.
module jelly3_rr_select
    import jelly3_axi4s_arb_pkg::*;
#(
    parameter int NUM_S    = 4,
    parameter int SEL_BITS = (NUM_S > 1) ? $clog2(NUM_S) : 1
)(
    input  logic [NUM_S-1:0]    req,
    input  logic [SEL_BITS-1:0] last,
    output logic                found,
    output logic [SEL_BITS-1:0] index
);

    // Outer loop walks priority order so the nearest requester after 'last' wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int o = 1; o <= NUM_S; o++) begin
            for (int j = 0; j < NUM_S; j++) begin
                if (!found && req[j] && (((int'(last) + o) % NUM_S) == j)) begin
                    found = 1'b1;
                    index = SEL_BITS'(j);
                end
            end
        end
    end

endmodule

// File: rtl/jelly3_axi4s_packet_arbiter.sv
// Packet-granular round-robin AXI4-Stream arbiter; 1-cycle registered output, one bubble per packet.
// s_tready follows the output slice; optional JELLY3_AXI4S_PACKET_ARBITER_STATS_EN adds pkt_count.
module jelly3_axi4s_packet_arbiter
    import jelly3_axi4s_arb_pkg::*;
#(
    parameter int NUM_S     = 4,
    parameter int SEL_BITS  = (NUM_S > 1) ? $clog2(NUM_S) : 1,
    parameter int DATA_BITS = 32,
    parameter int USER_BITS = 1,
    parameter bit USE_LAST  = 1'b1
)(
    input  logic                           aresetn,
    input  logic                           aclk,
    input  logic                           aclken,
    jelly3_axi4s_packet_arbiter_if.master  bus,
    output logic                           busy,
    output logic [31:0]                    pkt_count
);

    state_t              state, state_next;
    logic [SEL_BITS-1:0] grant, grant_next;
    logic [SEL_BITS-1:0] last_ptr, last_ptr_next;

    logic                rr_found;
    logic [SEL_BITS-1:0] rr_index;

    logic                 load;
    logic                 src_hs;
    logic                 src_last;
    logic [DATA_BITS-1:0] sel_tdata;
    logic [USER_BITS-1:0] sel_tuser;
    logic                 sel_tlast;
    logic                 sel_tvalid;

    jelly3_rr_select #(
        .NUM_S    (NUM_S),
        .SEL_BITS (SEL_BITS)
    ) u_rr_select (
        .req   (bus.s_tvalid),
        .last  (last_ptr),
        .found (rr_found),
        .index (rr_index)
    );

    always_comb begin
        sel_tdata  = '0;
        sel_tuser  = '0;
        sel_tlast  = 1'b0;
        sel_tvalid = 1'b0;
        for (int i = 0; i < NUM_S; i++) begin
            if (grant == SEL_BITS'(i)) begin
                sel_tdata  = bus.s_tdata[i*DATA_BITS +: DATA_BITS];
                sel_tuser  = bus.s_tuser[i*USER_BITS +: USER_BITS];
                sel_tlast  = bus.s_tlast[i];
                sel_tvalid = bus.s_tvalid[i];
            end
        end
    end

    // Ready depends only on state and the output slice, never on s_tvalid.
    assign load     = aclken & (~bus.m_tvalid | bus.m_tready);
    assign src_hs   = (state == GRANT) & load & sel_tvalid;
    assign src_last = USE_LAST ? sel_tlast : 1'b1;
    assign busy     = (state == GRANT);

    always_comb begin
        bus.s_tready = '0;
        for (int i = 0; i < NUM_S; i++) begin
            bus.s_tready[i] = (state == GRANT) && (grant == SEL_BITS'(i)) && load;
        end
    end

    always_comb begin
        state_next    = state;
        grant_next    = grant;
        last_ptr_next = last_ptr;
        case (state)
            IDLE: begin
                if (aclken && rr_found) begin
                    state_next    = GRANT;
                    grant_next    = rr_index;
                    last_ptr_next = rr_index;
                end
            end
            GRANT: begin
                if (src_hs && src_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            grant    <= '0;
            last_ptr <= SEL_BITS'(NUM_S - 1);
        end else begin
            state    <= state_next;
            grant    <= grant_next;
            last_ptr <= last_ptr_next;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bus.m_tvalid <= 1'b0;
            bus.m_tdata  <= '0;
            bus.m_tuser  <= '0;
            bus.m_tlast  <= 1'b0;
            bus.m_tid    <= '0;
        end else if (load) begin
            bus.m_tvalid <= src_hs;
            if (src_hs) begin
                bus.m_tdata <= sel_tdata;
                bus.m_tuser <= sel_tuser;
                bus.m_tlast <= src_last;
                bus.m_tid   <= grant;
            end
        end
    end

`ifdef JELLY3_AXI4S_PACKET_ARBITER_STATS_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_count <= '0;
        end else if (aclken && bus.m_tvalid && bus.m_tready && bus.m_tlast) begin
            pkt_count <= pkt_count + 32'd1;
        end
    end
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_jelly3_axi4s_packet_arbiter.sv
// Directed bench for the packet arbiter: one USE_LAST=1 instance and one USE_LAST=0 instance.
module tb_jelly3_axi4s_packet_arbiter;

    localparam int NS = 4;
    localparam int DW = 32;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        aclken;
    logic        busy, busy_nl;
    logic [31:0] pkt_count, pkt_count_nl;

    always #5 aclk = ~aclk;

    jelly3_axi4s_packet_arbiter_if #(.NUM_S(NS), .DATA_BITS(DW), .USER_BITS(1)) bus ();
    jelly3_axi4s_packet_arbiter_if #(.NUM_S(NS), .DATA_BITS(DW), .USER_BITS(1)) bus_nl ();

    jelly3_axi4s_packet_arbiter #(
        .NUM_S(NS), .DATA_BITS(DW), .USER_BITS(1), .USE_LAST(1'b1)
    ) dut (
        .aresetn   (aresetn),
        .aclk      (aclk),
        .aclken    (aclken),
        .bus       (bus),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    jelly3_axi4s_packet_arbiter #(
        .NUM_S(NS), .DATA_BITS(DW), .USER_BITS(1), .USE_LAST(1'b0)
    ) dut_nl (
        .aresetn   (aresetn),
        .aclk      (aclk),
        .aclken    (aclken),
        .bus       (bus_nl),
        .busy      (busy_nl),
        .pkt_count (pkt_count_nl)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // per-port source beats: [33]=user, [32]=last, [31:0]=data
    logic [33:0]   src_mem [NS][16];
    int            src_rd [NS];
    int            src_wr [NS];
    logic [NS-1:0] hold;

    logic [31:0] out_dat [64];
    logic [1:0]  out_id  [64];
    logic        out_last[64];
    logic        out_user[64];
    int          out_cyc [64];
    int          n_out;

    logic [31:0] nl_dat [64];
    logic [1:0]  nl_id  [64];
    logic        nl_last[64];
    int          n_nl;

    logic          smp_busy, smp_m_tvalid, smp_m_tlast, smp_m_tuser;
    logic [NS-1:0] smp_s_tready;
    logic [31:0]   smp_m_tdata, smp_pkt;
    logic [1:0]    smp_m_tid;

    task automatic push(input int p, input logic [31:0] d, input logic l, input logic u);
        src_mem[p][src_wr[p]] = {u, l, d};
        src_wr[p]++;
    endtask

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            logic [33:0] b;
            b = (src_rd[i] < src_wr[i]) ? src_mem[i][src_rd[i]] : 34'd0;
            bus.s_tdata[i*DW +: DW] = b[31:0];
            bus.s_tlast[i]          = b[32];
            bus.s_tuser[i]          = b[33];
            bus.s_tvalid[i]         = (src_rd[i] < src_wr[i]) && !hold[i];
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NS; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
        hold = '0;
        drive();
    endtask

    // Samples at the falling edge, then advances past the rising edge.
    task automatic tick();
        logic [NS-1:0] hs_v;
        @(negedge aclk);
        smp_busy     = busy;
        smp_s_tready = bus.s_tready;
        smp_m_tvalid = bus.m_tvalid;
        smp_m_tdata  = bus.m_tdata;
        smp_m_tid    = bus.m_tid;
        smp_m_tlast  = bus.m_tlast;
        smp_m_tuser  = bus.m_tuser;
        smp_pkt      = pkt_count;
        hs_v         = bus.s_tvalid & bus.s_tready;
        if (bus.m_tvalid && bus.m_tready && n_out < 64) begin
            out_dat[n_out]  = bus.m_tdata;
            out_id[n_out]   = bus.m_tid;
            out_last[n_out] = bus.m_tlast;
            out_user[n_out] = bus.m_tuser;
            out_cyc[n_out]  = cyc;
            n_out++;
        end
        if (bus_nl.m_tvalid && bus_nl.m_tready && n_nl < 64) begin
            nl_dat[n_nl]  = bus_nl.m_tdata;
            nl_id[n_nl]   = bus_nl.m_tid;
            nl_last[n_nl] = bus_nl.m_tlast;
            n_nl++;
        end
        @(posedge aclk);
        #1;
        cyc++;
        for (int i = 0; i < NS; i++) if (hs_v[i]) src_rd[i]++;
        drive();
    endtask

    task automatic apply_reset();
        aresetn = 1'b0;
        aclken  = 1'b1;
        bus.m_tready = 1'b1;
        clear_sources();
        bus_nl.s_tdata  = '0;
        bus_nl.s_tuser  = '0;
        bus_nl.s_tlast  = '0;
        bus_nl.s_tvalid = '0;
        bus_nl.m_tready = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        n_out   = 0;
        n_nl    = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        aresetn = 1'b0;
        push(0, 32'h1234_5678, 1'b1, 1'b1);
        drive();
        tick();
        vectors++; if (smp_m_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_m_tvalid got %0b want 0", smp_m_tvalid); end
        vectors++; if (smp_m_tdata !== 32'h0) begin miscompares++; $display("FAIL reset_m_tdata got %h want 0", smp_m_tdata); end
        vectors++; if ({smp_m_tlast, smp_m_tuser, smp_m_tid} !== 4'b0) begin miscompares++; $display("FAIL reset_last_user_tid got %b want 0000", {smp_m_tlast, smp_m_tuser, smp_m_tid}); end
        vectors++; if (smp_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", smp_busy); end
        vectors++; if (smp_s_tready !== 4'b0) begin miscompares++; $display("FAIL reset_s_tready got %b want 0000", smp_s_tready); end
        vectors++; if (smp_pkt !== 32'd0) begin miscompares++; $display("FAIL reset_pkt_count got %0d want 0", smp_pkt); end
        vectors++; if ({bus_nl.m_tvalid, busy_nl, bus_nl.s_tready} !== 6'b0) begin miscompares++; $display("FAIL reset_nl_outputs got %b want 0", {bus_nl.m_tvalid, busy_nl, bus_nl.s_tready}); end
        aresetn = 1'b1;
    endtask

    task automatic test_single_packet();
        logic          bz [8];
        logic [NS-1:0] rdy[8];
        int            c0;
        apply_reset();
        push(2, 32'hA2A2_0000, 1'b0, 1'b0);
        push(2, 32'hA2A2_0001, 1'b0, 1'b1);
        push(2, 32'hA2A2_0002, 1'b1, 1'b0);
        drive();
        c0 = cyc;
        for (int t = 0; t < 8; t++) begin
            tick();
            bz[t]  = smp_busy;
            rdy[t] = smp_s_tready;
        end
        vectors++; if (bz[0] !== 1'b0) begin miscompares++; $display("FAIL single_busy_idle got %0b want 0", bz[0]); end
        vectors++; if (bz[1] !== 1'b1 || rdy[1] !== 4'b0100) begin miscompares++; $display("FAIL single_grant busy %0b rdy %b want 1 0100", bz[1], rdy[1]); end
        vectors++; if (bz[4] !== 1'b0) begin miscompares++; $display("FAIL single_busy_drop got %0b want 0", bz[4]); end
        vectors++; if (n_out !== 3) begin miscompares++; $display("FAIL single_count got %0d want 3", n_out); end
        vectors++; if (out_cyc[0] !== c0 + 2) begin miscompares++; $display("FAIL single_latency got %0d want %0d", out_cyc[0], c0 + 2); end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (out_dat[k] !== 32'hA2A2_0000 + k || out_id[k] !== 2'd2 || out_last[k] !== (k == 2) ||
                out_user[k] !== (k == 1) || out_cyc[k] !== out_cyc[0] + k) begin
                miscompares++;
                $display("FAIL single_beat%0d got d=%h id=%0d l=%0b u=%0b c=%0d want d=%h id=2 l=%0b u=%0b c=%0d",
                         k, out_dat[k], out_id[k], out_last[k], out_user[k], out_cyc[k],
                         32'hA2A2_0000 + k, (k == 2), (k == 1), out_cyc[0] + k);
            end
        end
    endtask

    task automatic test_round_robin();
        int ord [5] = '{0, 1, 2, 3, 0};
        int pk  [5] = '{0, 0, 0, 0, 1};
        apply_reset();
        for (int p = 0; p < NS; p++)
            for (int q = 0; q < 2; q++)
                for (int b = 0; b < 2; b++)
                    push(p, 32'((p << 8) | (q << 4) | b), b == 1, 1'b0);
        drive();
        for (int t = 0; t < 20; t++) tick();
        vectors++; if (n_out < 10) begin miscompares++; $display("FAIL rr_count got %0d want >=10", n_out); end
        for (int k = 0; k < 10; k++) begin
            logic [31:0] exp_d;
            exp_d = 32'((ord[k/2] << 8) | (pk[k/2] << 4) | (k % 2));
            vectors++;
            if (out_id[k] !== 2'(ord[k/2]) || out_dat[k] !== exp_d || out_last[k] !== (k % 2 == 1)) begin
                miscompares++;
                $display("FAIL rr_beat%0d got id=%0d d=%h l=%0b want id=%0d d=%h l=%0b",
                         k, out_id[k], out_dat[k], out_last[k], ord[k/2], exp_d, (k % 2 == 1));
            end
        end
        for (int k = 0; k < 9; k++) begin
            vectors++;
            if (out_cyc[k+1] - out_cyc[k] !== ((k % 2 == 0) ? 1 : 2)) begin
                miscompares++;
                $display("FAIL rr_gap%0d got %0d want %0d", k, out_cyc[k+1] - out_cyc[k], (k % 2 == 0) ? 1 : 2);
            end
        end
    endtask

    task automatic test_packet_lock();
        int held = 0;
        apply_reset();
        for (int b = 0; b < 4; b++) push(0, 32'h0C00 + b, b == 3, 1'b0);
        for (int b = 0; b < 2; b++) push(1, 32'h0D00 + b, b == 1, 1'b0);
        for (int t = 0; t < 30; t++) begin
            hold[0] = (src_rd[0] == 2) && (held < 5);
            if (hold[0]) held++;
            drive();
            tick();
        end
        vectors++; if (n_out !== 6) begin miscompares++; $display("FAIL lock_count got %0d want 6", n_out); end
        for (int k = 0; k < 6; k++) begin
            logic [1:0]  exp_id;
            logic [31:0] exp_d;
            exp_id = (k < 4) ? 2'd0 : 2'd1;
            exp_d  = (k < 4) ? 32'h0C00 + k : 32'h0D00 + (k - 4);
            vectors++;
            if (out_id[k] !== exp_id || out_dat[k] !== exp_d || out_last[k] !== (k == 3 || k == 5)) begin
                miscompares++;
                $display("FAIL lock_beat%0d got id=%0d d=%h l=%0b want id=%0d d=%h", k, out_id[k], out_dat[k], out_last[k], exp_id, exp_d);
            end
        end
        vectors++; if (out_cyc[2] - out_cyc[1] !== 6) begin miscompares++; $display("FAIL lock_hold_gap got %0d want 6", out_cyc[2] - out_cyc[1]); end
    endtask

    task automatic test_backpressure();
        logic tbl [10] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
        apply_reset();
        for (int b = 0; b < 4; b++) push(1, 32'h5100 + b, b == 3, 1'b0);
        for (int t = 0; t < 10; t++) begin
            bus.m_tready = tbl[t];
            drive();
            tick();
            if (t == 4 || t == 5) begin
                vectors++;
                if (smp_m_tvalid !== 1'b1 || smp_m_tdata !== 32'h5102 || smp_m_tid !== 2'd1 || smp_s_tready !== 4'b0) begin
                    miscompares++;
                    $display("FAIL stall_t%0d got v=%0b d=%h id=%0d rdy=%b want v=1 d=00005102 id=1 rdy=0000",
                             t, smp_m_tvalid, smp_m_tdata, smp_m_tid, smp_s_tready);
                end
            end
        end
        vectors++; if (n_out !== 4) begin miscompares++; $display("FAIL stall_count got %0d want 4", n_out); end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (out_dat[k] !== 32'h5100 + k || out_id[k] !== 2'd1) begin
                miscompares++;
                $display("FAIL stall_beat%0d got d=%h id=%0d want d=%h id=1", k, out_dat[k], out_id[k], 32'h5100 + k);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [31:0] exp_pkt;
        apply_reset();
        for (int b = 0; b < 4; b++) push(3, 32'h3300 + b, b == 3, 1'b0);
        drive();
        for (int t = 0; t < 3; t++) tick();
        vectors++; if (smp_m_tvalid !== 1'b1 || smp_m_tid !== 2'd3) begin miscompares++; $display("FAIL midrst_pre got v=%0b id=%0d want v=1 id=3", smp_m_tvalid, smp_m_tid); end
        aresetn = 1'b0;
        tick();
        vectors++;
        if ({smp_m_tvalid, smp_m_tlast, smp_m_tuser, smp_m_tid, smp_busy, smp_s_tready} !== 10'b0 || smp_m_tdata !== 32'h0) begin
            miscompares++;
            $display("FAIL midrst_outputs got v=%0b l=%0b u=%0b id=%0d busy=%0b rdy=%b d=%h want all 0",
                     smp_m_tvalid, smp_m_tlast, smp_m_tuser, smp_m_tid, smp_busy, smp_s_tready, smp_m_tdata);
        end
        vectors++; if (smp_pkt !== 32'd0) begin miscompares++; $display("FAIL midrst_pkt_reset got %0d want 0", smp_pkt); end
        clear_sources();
        aresetn = 1'b1;
        n_out = 0;
        push(1, 32'h1100, 1'b0, 1'b0);
        push(1, 32'h1101, 1'b1, 1'b0);
        drive();
        for (int t = 0; t < 6; t++) tick();
        vectors++; if (n_out !== 2 || out_id[0] !== 2'd1 || out_dat[0] !== 32'h1100) begin miscompares++; $display("FAIL midrst_regrant got n=%0d id=%0d d=%h want n=2 id=1 d=00001100", n_out, out_id[0], out_dat[0]); end
`ifdef JELLY3_AXI4S_PACKET_ARBITER_STATS_EN
        exp_pkt = 32'd1;
`else
        exp_pkt = 32'd0;
`endif
        vectors++; if (smp_pkt !== exp_pkt) begin miscompares++; $display("FAIL midrst_pkt_count got %0d want %0d", smp_pkt, exp_pkt); end
    endtask

    task automatic test_no_last();
        apply_reset();
        bus_nl.s_tdata  = {32'h0, 32'h0, 32'h0000_0101, 32'h0000_0100};
        bus_nl.s_tlast  = 4'b0000;
        bus_nl.s_tuser  = 4'b0000;
        bus_nl.s_tvalid = 4'b0011;
        bus_nl.m_tready = 1'b1;
        for (int t = 0; t < 12; t++) tick();
        vectors++; if (n_nl < 4) begin miscompares++; $display("FAIL nolast_count got %0d want >=4", n_nl); end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (nl_id[k] !== 2'(k % 2) || nl_last[k] !== 1'b1 || nl_dat[k] !== 32'h100 + (k % 2)) begin
                miscompares++;
                $display("FAIL nolast_beat%0d got id=%0d l=%0b d=%h want id=%0d l=1 d=%h", k, nl_id[k], nl_last[k], nl_dat[k], k % 2, 32'h100 + (k % 2));
            end
        end
        bus_nl.s_tvalid = 4'b0000;
    endtask

    initial begin
        aresetn = 1'b1;
        aclken  = 1'b1;
        bus.m_tready = 1'b0;
        for (int i = 0; i < NS; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
        hold  = '0;
        n_out = 0;
        n_nl  = 0;
        drive();
        bus_nl.s_tdata  = '0;
        bus_nl.s_tuser  = '0;
        bus_nl.s_tlast  = '0;
        bus_nl.s_tvalid = '0;
        bus_nl.m_tready = 1'b0;
        #2;
        aresetn = 1'b0;

        test_reset();
        test_single_packet();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_reset_mid_packet();
        test_no_last();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
